// File: rtl/overlay_pkg.sv
// Shared types and default geometry for the overlay screen sequencer.
// Request bits are ordered {over, fuel, title}, lowest rank in bit 0.
package overlay_pkg;

    localparam int H_ACTIVE_DEF     = 640;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int IMG_W_DEF        = 44;
    localparam int IMG_H_DEF        = 22;
    localparam int BLINK_FRAMES_DEF = 15;
    localparam int FUEL_FRAMES_DEF  = 180;

    localparam int ADDR_W = $clog2(IMG_W_DEF * IMG_H_DEF);

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_TITLE = 2'b01,
        SEL_FUEL  = 2'b10,
        SEL_OVER  = 2'b11
    } overlay_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TITLE,
        ST_FUEL,
        ST_OVER
    } state_t;

    // Image shown for a given sequencer state.
    function automatic overlay_sel_t sel_of(state_t s);
        case (s)
            ST_TITLE: return SEL_TITLE;
            ST_FUEL:  return SEL_FUEL;
            ST_OVER:  return SEL_OVER;
            default:  return SEL_NONE;
        endcase
    endfunction

    // Requests that still matter in a state: only those that outrank it.
    function automatic logic [2:0] keep_mask(state_t s);
        case (s)
            ST_IDLE:  return 3'b111;
            ST_TITLE: return 3'b110;
            ST_FUEL:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/overlay_addr_gen.sv
// Scaled overlay ROM address from the pixel position.
// Column and row are tracked with modulo accumulators, no multiplier.
module overlay_addr_gen
    import overlay_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int IMG_W    = IMG_W_DEF,
    parameter int IMG_H    = IMG_H_DEF
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    output logic [ADDR_W-1:0] rom_address
);

    localparam int CW = 10;
    localparam int SW = CW + 1;

    logic [CW-1:0]     xprev_q, yprev_q;
    logic [CW-1:0]     cacc_q, cacc_d;
    logic [CW-1:0]     col_q, col_d;
    logic [CW-1:0]     racc_q, racc_d;
    logic [CW-1:0]     row_q, row_d;
    logic [CW-1:0]     rbase_q, rbase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SW-1:0]     csum, rsum;

    // Column: step IMG_W per new pixel, carry into the column on wrap.
    always_comb begin
        cacc_d = cacc_q;
        col_d  = col_q;
        csum   = {1'b0, cacc_q} + SW'(IMG_W);
        if (DrawX == '0) begin
            cacc_d = '0;
            col_d  = '0;
        end else if (DrawX != xprev_q) begin
            if (csum >= SW'(H_ACTIVE)) begin
                cacc_d = CW'(csum - SW'(H_ACTIVE));
                if (col_q != CW'(IMG_W - 1))
                    col_d = col_q + 1'b1;
            end else begin
                cacc_d = csum[CW-1:0];
            end
        end
    end

    // Row: step IMG_H per new line, row base advances by one image width.
    always_comb begin
        racc_d  = racc_q;
        row_d   = row_q;
        rbase_d = rbase_q;
        rsum    = {1'b0, racc_q} + SW'(IMG_H);
        if (DrawY == '0) begin
            racc_d  = '0;
            row_d   = '0;
            rbase_d = '0;
        end else if (DrawY != yprev_q) begin
            if (rsum >= SW'(V_ACTIVE)) begin
                racc_d = CW'(rsum - SW'(V_ACTIVE));
                if (row_q != CW'(IMG_H - 1)) begin
                    row_d   = row_q + 1'b1;
                    rbase_d = rbase_q + CW'(IMG_W);
                end
            end else begin
                racc_d = rsum[CW-1:0];
            end
        end
    end

    // Texel index for the current pixel, forced to 0 outside active video.
    always_comb begin
        addr_d = '0;
        if (blank)
            addr_d = ADDR_W'(col_d + rbase_d);
    end

    // Scaler state and the one-cycle address register.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            xprev_q <= '0;
            yprev_q <= '0;
            cacc_q  <= '0;
            col_q   <= '0;
            racc_q  <= '0;
            row_q   <= '0;
            rbase_q <= '0;
            addr_q  <= '0;
        end else begin
            xprev_q <= DrawX;
            yprev_q <= DrawY;
            cacc_q  <= cacc_d;
            col_q   <= col_d;
            racc_q  <= racc_d;
            row_q   <= row_d;
            rbase_q <= rbase_d;
            addr_q  <= addr_d;
        end
    end

    assign rom_address = addr_q;

endmodule

// File: rtl/overlay_screen_ctrl.sv
// Overlay screen sequencer: request arbitration on frame boundaries,
// fuel-empty blink timing, and the scaled overlay ROM address.
module overlay_screen_ctrl
    import overlay_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int IMG_W        = IMG_W_DEF,
    parameter int IMG_H        = IMG_H_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF,
    parameter int FUEL_FRAMES  = FUEL_FRAMES_DEF
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              title_req,
    input  logic              fuel_req,
    input  logic              over_req,
    input  logic              dismiss,
    output logic              overlay_en,
    output logic [1:0]        overlay_sel,
    output logic [ADDR_W-1:0] rom_address,
    output logic              busy
);

    localparam int FW = $clog2(FUEL_FRAMES);
    localparam int BW = $clog2(BLINK_FRAMES);

    state_t       state_q, state_d;
    logic [2:0]   pend_q, pend_d;
    logic         dis_q, dis_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic         phase_q, phase_d;
    logic         orig_q;
    overlay_sel_t sel_q;
    logic         en_q;
    logic         at_origin;
    logic         frame_start;
    logic [2:0]   req;

    assign at_origin   = (DrawX == '0) && (DrawY == '0);
    assign frame_start = at_origin && !orig_q;
    assign req         = {over_req, fuel_req, title_req};

    // Frame-boundary arbitration; new pulses only count from next frame.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        dis_d   = dis_q;
        fcnt_d  = fcnt_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pend_q[2])      state_d = ST_OVER;
                    else if (pend_q[1]) state_d = ST_FUEL;
                    else if (pend_q[0]) state_d = ST_TITLE;
                end
                ST_TITLE: begin
                    if (pend_q[2])      state_d = ST_OVER;
                    else if (pend_q[1]) state_d = ST_FUEL;
                    else if (dis_q)     state_d = ST_IDLE;
                end
                ST_FUEL: begin
                    if (pend_q[2])
                        state_d = ST_OVER;
                    else if (dis_q || fcnt_q == FW'(FUEL_FRAMES - 1))
                        state_d = ST_IDLE;
                end
                ST_OVER: begin
                    if (dis_q)          state_d = ST_IDLE;
                end
            endcase
            if (state_d == ST_FUEL) begin
                if (state_q != ST_FUEL) begin
                    fcnt_d  = '0;
                    bcnt_d  = '0;
                    phase_d = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                    if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                        bcnt_d  = '0;
                        phase_d = !phase_q;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            pend_d = pend_q & keep_mask(state_d);
            dis_d  = 1'b0;
        end
        pend_d = pend_d | (req & keep_mask(state_q));
        dis_d  = dis_d | (dismiss && state_q != ST_IDLE);
    end

    // Sequencer state with registered select and enable outputs.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            dis_q   <= 1'b0;
            fcnt_q  <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            orig_q  <= 1'b0;
            sel_q   <= SEL_NONE;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dis_q   <= dis_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            orig_q  <= at_origin;
            sel_q   <= sel_of(state_d);
            en_q    <= (state_d != ST_IDLE) && blank &&
                       (state_d != ST_FUEL || phase_d);
        end
    end

    overlay_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H)
    ) u_addr (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .rom_address (rom_address)
    );

    assign overlay_en  = en_q;
    assign overlay_sel = sel_q;
    assign busy        = (state_q != ST_IDLE) || (|pend_q);

endmodule

// File: tb/tb_overlay_screen_ctrl.sv
// Bench for overlay_screen_ctrl: address sweep with checkpoints, event
// scenarios on short frames, and random requests against a frame model.
module tb_overlay_screen_ctrl;

    localparam int FUEL_N  = 180;
    localparam int BLINK_N = 15;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       blank = 1'b0;
    logic       title_req = 1'b0;
    logic       fuel_req = 1'b0;
    logic       over_req = 1'b0;
    logic       dismiss = 1'b0;
    logic       overlay_en;
    logic [1:0] overlay_sel;
    logic [9:0] rom_address;
    logic       busy;

    overlay_screen_ctrl dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .title_req   (title_req),
        .fuel_req    (fuel_req),
        .over_req    (over_req),
        .dismiss     (dismiss),
        .overlay_en  (overlay_en),
        .overlay_sel (overlay_sel),
        .rom_address (rom_address),
        .busy        (busy)
    );

    always #5 vga_clk = ~vga_clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model: mode 0 idle, 1 title, 2 fuel, 3 over (mode == rank).
    int m_mode;
    bit mp [1:3];
    bit m_dis;
    int m_fn;
    bit m_pz;
    bit a_ok;

    int fr;
    int sel_at [0:255];
    bit en_at [0:255];

    typedef struct {
        int x;
        int y;
        int exp;
    } pt_t;
    pt_t pts [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic model_reset();
        m_mode = 0;
        for (int k = 1; k <= 3; k++) mp[k] = 0;
        m_dis = 0;
        m_fn = 0;
        m_pz = 0;
        a_ok = 0;
    endtask

    task automatic model_step(input int x, input int y, input bit t,
                              input bit f, input bit o, input bit d);
        bit org;
        bit fs;
        int om;
        int best;
        int nm;
        org = (x == 0 && y == 0);
        fs = org && !m_pz;
        m_pz = org;
        om = m_mode;
        if (fs) begin
            best = 0;
            for (int k = 1; k <= 3; k++) if (mp[k]) best = k;
            nm = m_mode;
            if (best > m_mode) nm = best;
            else if (m_dis) nm = 0;
            else if (m_mode == 2 && m_fn == FUEL_N - 1) nm = 0;
            if (nm == 2) m_fn = (m_mode == 2) ? m_fn + 1 : 0;
            for (int k = 1; k <= 3; k++) if (k <= nm) mp[k] = 0;
            m_dis = 0;
            m_mode = nm;
        end
        if (t && 1 > om) mp[1] = 1;
        if (f && 2 > om) mp[2] = 1;
        if (o && 3 > om) mp[3] = 1;
        if (d && om != 0) m_dis = 1;
    endtask

    task automatic cyc(input int x, input int y, input bit bl, input bit t,
                       input bit f, input bit o, input bit d);
        int e_en;
        int e_busy;
        int e_addr;
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
        title_req = t;
        fuel_req = f;
        over_req = o;
        dismiss = d;
        @(posedge vga_clk);
        #1;
        model_step(x, y, t, f, o, d);
        if (x == 0 && y == 0) a_ok = 1;
        e_en = (m_mode != 0 && bl &&
                (m_mode != 2 || (m_fn / BLINK_N) % 2 == 0)) ? 1 : 0;
        e_busy = (m_mode != 0 || mp[1] || mp[2] || mp[3]) ? 1 : 0;
        e_addr = bl ? (x * 44 / 640 + (y * 22 / 480) * 44) : 0;
        chk("sel", overlay_sel, m_mode);
        chk("en", overlay_en, e_en);
        chk("busy", busy, e_busy);
        if (a_ok) chk("addr", rom_address, e_addr);
    endtask

    // Short 6x2 frame; x 4..5 is horizontal blanking.
    task automatic frame(input int rc, input bit t, input bit f,
                         input bit o, input bit d);
        int c;
        c = 0;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 6; x++) begin
                cyc(x, y, x < 4, t && c == rc, f && c == rc,
                    o && c == rc, d && c == rc);
                if (c == 0 && fr < 256) begin
                    sel_at[fr] = overlay_sel;
                    en_at[fr] = overlay_en;
                end
                c++;
            end
        end
        fr++;
    endtask

    task automatic sweep();
        int xe;
        bit full;
        for (int y = 0; y < 480; y++) begin
            full = (y % 40 == 0) || y == 21 || y == 22 || y == 100 ||
                   y == 239 || y == 240 || y == 479;
            xe = full ? 644 : 4;
            for (int x = 0; x < xe; x++) begin
                cyc(x, y, x < 640, 0, 0, 0, 0);
                for (int i = 0; i < 10; i++)
                    if (pts[i].x == x && pts[i].y == y)
                        chk($sformatf("addr(%0d,%0d)", x, y),
                            rom_address, pts[i].exp);
            end
        end
    endtask

    initial begin
        pts[0] = '{639, 479, 967};
        pts[1] = '{15, 22, 45};
        pts[2] = '{0, 0, 0};
        pts[3] = '{320, 240, 506};
        pts[4] = '{100, 100, 182};
        pts[5] = '{14, 21, 0};
        pts[6] = '{15, 21, 1};
        pts[7] = '{639, 0, 43};
        pts[8] = '{0, 479, 924};
        pts[9] = '{641, 240, 0};

        #1 reset_n = 1'b0;
        #2;
        chk("rst en", overlay_en, 0);
        chk("rst sel", overlay_sel, 0);
        chk("rst addr", rom_address, 0);
        chk("rst busy", busy, 0);
        model_reset();
        @(posedge vga_clk);
        #1 reset_n = 1'b1;

        sweep();

        // fuel-empty blink and timeout
        fr = 0;
        for (int i = 0; i < 3; i++) frame(-1, 0, 0, 0, 0);
        frame(5, 0, 1, 0, 0);
        while (fr < 186) frame(-1, 0, 0, 0, 0);
        chk("f3 sel", sel_at[3], 0);
        chk("f4 sel", sel_at[4], 2);
        chk("f4 en", en_at[4], 1);
        chk("f18 en", en_at[18], 1);
        chk("f19 en", en_at[19], 0);
        chk("f33 en", en_at[33], 0);
        chk("f34 en", en_at[34], 1);
        chk("f48 en", en_at[48], 1);
        chk("f49 en", en_at[49], 0);
        chk("f183 sel", sel_at[183], 2);
        chk("f184 sel", sel_at[184], 0);

        // title and fuel together: fuel wins, title dropped
        fr = 0;
        frame(3, 1, 1, 0, 0);
        frame(-1, 0, 0, 0, 0);
        frame(2, 0, 0, 0, 1);
        frame(-1, 0, 0, 0, 0);
        frame(-1, 0, 0, 0, 0);
        chk("tf sel", sel_at[1], 2);
        chk("tf dismissed", sel_at[3], 0);
        chk("tf no title", sel_at[4], 0);
        chk("tf busy", busy, 0);

        // over preempts fuel at fuel frame 50, then only dismiss counts
        fr = 0;
        frame(1, 0, 1, 0, 0);
        while (fr < 51) frame(-1, 0, 0, 0, 0);
        frame(4, 0, 0, 1, 0);
        frame(1, 1, 1, 0, 0);
        frame(7, 0, 0, 0, 1);
        frame(-1, 0, 0, 0, 0);
        frame(-1, 0, 0, 0, 0);
        chk("ov f51", sel_at[51], 2);
        chk("ov f52", sel_at[52], 3);
        chk("ov f53", sel_at[53], 3);
        chk("ov f54", sel_at[54], 0);
        chk("ov f55", sel_at[55], 0);

        // over on the frame_start cycle applies one frame later
        fr = 0;
        frame(-1, 0, 0, 0, 0);
        frame(0, 0, 0, 1, 0);
        frame(3, 0, 0, 0, 1);
        frame(-1, 0, 0, 0, 0);
        chk("fs f1", sel_at[1], 0);
        chk("fs f2", sel_at[2], 3);
        chk("fs f3", sel_at[3], 0);

        // asynchronous reset in the middle of a title line
        fr = 0;
        frame(2, 1, 0, 0, 0);
        frame(-1, 0, 0, 0, 0);
        chk("rs title", sel_at[1], 1);
        cyc(0, 0, 1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        cyc(2, 0, 1, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("arst en", overlay_en, 0);
        chk("arst sel", overlay_sel, 0);
        chk("arst addr", rom_address, 0);
        chk("arst busy", busy, 0);
        model_reset();
        @(posedge vga_clk);
        #1 reset_n = 1'b1;
        for (int x = 3; x < 6; x++) cyc(x, 0, x < 4, 0, 0, 0, 0);
        for (int x = 0; x < 6; x++) cyc(x, 1, x < 4, 0, 0, 0, 0);
        fr = 0;
        frame(-1, 0, 0, 0, 0);
        frame(-1, 0, 0, 0, 0);
        chk("rs idle sel", sel_at[1], 0);
        chk("rs idle busy", busy, 0);

        // random requests against the model
        for (int i = 0; i < 150; i++) begin
            frame($urandom_range(0, 11),
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
